// File: rtl/regfile_scoreboard_if.sv
// Register file bus: read ports, two write ports, issue/flush.
// The core drives master, the register file takes slave.
interface regfile_scoreboard_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2
);
  localparam int AW = $clog2(NREG);

  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rs_dout;
  logic [NRD-1:0]      rs_busy;
  logic                hazard;
  logic                wa_en;
  logic [AW-1:0]       wa_addr;
  logic [XLEN-1:0]     wa_data;
  logic                wb_en;
  logic [AW-1:0]       wb_addr;
  logic [XLEN-1:0]     wb_data;
  logic                iss_en;
  logic [AW-1:0]       iss_rd;
  logic                flush;

  modport master (
    output rs_addr, wa_en, wa_addr, wa_data,
    output wb_en, wb_addr, wb_data,
    output iss_en, iss_rd, flush,
    input  rs_dout, rs_busy, hazard
  );

  modport slave (
    input  rs_addr, wa_en, wa_addr, wa_data,
    input  wb_en, wb_addr, wb_data,
    input  iss_en, iss_rd, flush,
    output rs_dout, rs_busy, hazard
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Multi-port integer register file with two write ports,
// write-to-read bypass and per-register pending bits.
module regfile_scoreboard #(
  parameter int              XLEN    = 32,
  parameter int              NREG    = 32,
  parameter int              NRD     = 2,
  parameter int              SP_IDX  = 2,
  parameter logic [XLEN-1:0] SP_INIT = 32'h2ffc,
  parameter bit              BYPASS  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_scoreboard_if.slave  bus,
  output logic [NREG*XLEN-1:0] print_reg
);
  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pend;
  logic [NREG-1:0] wa_hit;
  logic [NREG-1:0] wb_hit;
  logic [NRD-1:0]  busy_v;

  // one-hot write targets; x0 never counts as a target
  always_comb begin
    wa_hit = '0;
    wb_hit = '0;
    if (bus.wa_en) wa_hit[bus.wa_addr] = 1'b1;
    if (bus.wb_en) wb_hit[bus.wb_addr] = 1'b1;
    wa_hit[0] = 1'b0;
    wb_hit[0] = 1'b0;
  end

  // register storage: port B wins over A on the same address
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++)
        regs[r] <= (r == SP_IDX && r != 0) ? SP_INIT : '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (wb_hit[r])      regs[r] <= bus.wb_data;
        else if (wa_hit[r]) regs[r] <= bus.wa_data;
      end
    end
  end

  // pending bits: flush, then issue (younger producer), then writeback
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      pend <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (bus.iss_en && bus.iss_rd == AW'(r))
          pend[r] <= 1'b1;
        else if (wa_hit[r] || wb_hit[r])
          pend[r] <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] dout;
    logic            bsy;

    assign a = bus.rs_addr[k*AW +: AW];

    // read port: stored value or forwarded in-flight write
    always_comb begin
      dout = regs[a];
      bsy  = pend[a];
      if (BYPASS) begin
        if (wb_hit[a]) begin
          dout = bus.wb_data;
          bsy  = 1'b0;
        end else if (wa_hit[a]) begin
          dout = bus.wa_data;
          bsy  = 1'b0;
        end
      end
    end

    assign bus.rs_dout[k*XLEN +: XLEN] = dout;
    assign busy_v[k] = bsy;
  end

  assign bus.rs_busy = busy_v;
  assign bus.hazard  = |busy_v;

  for (genvar i = 0; i < NREG; i++) begin : g_pr
    assign print_reg[i*XLEN +: XLEN] = regs[i];
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: two DUTs (bypass/2 ports, no bypass/3 ports).
// Driver queues expectations; a negedge monitor checks them.
module tb_regfile_scoreboard;
  logic clk = 1'b0;
  logic reset;
  logic [32*32-1:0] p0;
  logic [32*32-1:0] p1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  regfile_scoreboard_if #(.XLEN(32), .NREG(32), .NRD(2)) b0 ();
  regfile_scoreboard_if #(.XLEN(32), .NREG(32), .NRD(3)) b1 ();

  regfile_scoreboard #(
    .XLEN(32), .NREG(32), .NRD(2), .SP_IDX(2),
    .SP_INIT(32'h2ffc), .BYPASS(1'b1)
  ) u0 (
    .clk(clk), .reset(reset), .bus(b0), .print_reg(p0)
  );

  regfile_scoreboard #(
    .XLEN(32), .NREG(32), .NRD(3), .SP_IDX(2),
    .SP_INIT(32'h2ffc), .BYPASS(1'b0)
  ) u1 (
    .clk(clk), .reset(reset), .bus(b1), .print_reg(p1)
  );

  typedef struct {
    int          cyc;
    int          dut;
    int          kind;
    int          idx;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t q[$];

  function automatic void want(int dut, int kind, int idx,
                               logic [31:0] v, string n);
    chk_t c;
    c.cyc  = cyc;
    c.dut  = dut;
    c.kind = kind;
    c.idx  = idx;
    c.exp  = v;
    c.name = n;
    q.push_back(c);
  endfunction

  function automatic logic [31:0] sample(chk_t c);
    logic [31:0] r;
    r = 'x;
    case (c.kind)
      0: r = c.dut == 0 ? b0.rs_dout[c.idx*32 +: 32]
                        : b1.rs_dout[c.idx*32 +: 32];
      1: r = {31'b0, c.dut == 0 ? b0.rs_busy[c.idx]
                                : b1.rs_busy[c.idx]};
      2: r = {31'b0, c.dut == 0 ? b0.hazard : b1.hazard};
      3: r = c.dut == 0 ? p0[c.idx*32 +: 32]
                        : p1[c.idx*32 +: 32];
      default: r = 'x;
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      chk_t c;
      logic [31:0] act;
      c = q.pop_front();
      act = sample(c);
      checks++;
      if (c.cyc != cyc || act !== c.exp) begin
        errors++;
        $display("FAIL %s: got %h want %h (cycle %0d)",
                 c.name, act, c.exp, c.cyc);
      end
    end
  end

  task automatic idle();
    b0.wa_en = 0; b0.wa_addr = 0; b0.wa_data = 0;
    b0.wb_en = 0; b0.wb_addr = 0; b0.wb_data = 0;
    b0.iss_en = 0; b0.iss_rd = 0; b0.flush = 0;
    b1.wa_en = 0; b1.wa_addr = 0; b1.wa_data = 0;
    b1.wb_en = 0; b1.wb_addr = 0; b1.wb_data = 0;
    b1.iss_en = 0; b1.iss_rd = 0; b1.flush = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic rd0(int p, logic [4:0] a);
    b0.rs_addr[p*5 +: 5] = a;
  endtask

  task automatic rd1(int p, logic [4:0] a);
    b1.rs_addr[p*5 +: 5] = a;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    b0.rs_addr = '0;
    b1.rs_addr = '0;
    idle();
    step();
    reset = 1'b0;
    rd0(0, 2);
    want(0, 0, 0, 32'h2ffc, "rst_sp_read");
    want(0, 0, 1, 32'h0, "rst_x0_read");
    want(0, 1, 0, 32'h0, "rst_busy");
    want(0, 2, 0, 32'h0, "rst_hazard");
    want(0, 3, 2, 32'h2ffc, "rst_print_sp");
    want(0, 3, 0, 32'h0, "rst_print_x0");
    want(0, 3, 31, 32'h0, "rst_print_r31");
    want(1, 3, 2, 32'h2ffc, "rst_print_sp_nb");

    step();
    b0.wa_en = 1; b0.wa_addr = 5; b0.wa_data = 32'hdeadbeef;
    rd0(0, 5);
    want(0, 0, 0, 32'hdeadbeef, "wr5_bypass");
    want(0, 3, 5, 32'h0, "wr5_print_old");

    step();
    want(0, 0, 0, 32'hdeadbeef, "wr5_stored");
    want(0, 3, 5, 32'hdeadbeef, "wr5_print");
    b0.wa_en = 1; b0.wa_addr = 0; b0.wa_data = 32'h1;
    rd0(1, 0);
    want(0, 0, 1, 32'h0, "x0_no_bypass");

    step();
    want(0, 0, 1, 32'h0, "x0_stored");
    want(0, 3, 0, 32'h0, "x0_print");
    b0.wa_en = 1; b0.wa_addr = 7; b0.wa_data = 32'h11;
    b0.wb_en = 1; b0.wb_addr = 7; b0.wb_data = 32'h22;
    rd0(0, 7);
    want(0, 0, 0, 32'h22, "dual_bypass_b");

    step();
    want(0, 0, 0, 32'h22, "dual_stored_b");
    want(0, 3, 7, 32'h22, "dual_print");

    step();
    b0.iss_en = 1; b0.iss_rd = 9;
    rd0(0, 9);
    want(0, 1, 0, 32'h0, "iss9_same_cyc");
    want(0, 2, 0, 32'h0, "iss9_haz_same");

    step();
    want(0, 1, 0, 32'h1, "iss9_busy");
    want(0, 2, 0, 32'h1, "iss9_hazard");

    step();
    want(0, 1, 0, 32'h1, "iss9_busy_hold");

    step();
    b0.wb_en = 1; b0.wb_addr = 9; b0.wb_data = 32'h99;
    want(0, 0, 0, 32'h99, "wb9_fwd_data");
    want(0, 1, 0, 32'h0, "wb9_fwd_busy");
    want(0, 2, 0, 32'h0, "wb9_fwd_haz");

    step();
    want(0, 1, 0, 32'h0, "wb9_cleared");
    want(0, 0, 0, 32'h99, "wb9_stored");
    want(0, 3, 9, 32'h99, "wb9_print");

    step();
    b0.iss_en = 1; b0.iss_rd = 4;
    b0.wa_en = 1; b0.wa_addr = 4; b0.wa_data = 32'h44;
    rd0(1, 4);
    want(0, 0, 1, 32'h44, "isswr4_fwd");
    want(0, 1, 1, 32'h0, "isswr4_busy_same");
    want(0, 2, 0, 32'h0, "isswr4_haz_same");

    step();
    want(0, 1, 1, 32'h1, "isswr4_pending");
    want(0, 0, 1, 32'h44, "isswr4_data");
    want(0, 2, 0, 32'h1, "isswr4_hazard");
    want(0, 3, 4, 32'h44, "isswr4_print");

    step();
    b0.flush = 1; b0.iss_en = 1; b0.iss_rd = 4;
    want(0, 1, 1, 32'h1, "flush_same_cyc");

    step();
    want(0, 1, 1, 32'h0, "flush_cleared");
    want(0, 2, 0, 32'h0, "flush_hazard");
    b0.iss_en = 1; b0.iss_rd = 0;
    rd0(0, 0);

    step();
    want(0, 1, 0, 32'h0, "iss_x0_ignored");
    want(0, 2, 0, 32'h0, "iss_x0_hazard");

    step();
    b1.iss_en = 1; b1.iss_rd = 3;
    rd1(2, 3);
    want(1, 1, 2, 32'h0, "nb_iss3_same");

    step();
    want(1, 1, 2, 32'h1, "nb_iss3_busy");
    want(1, 0, 2, 32'h0, "nb_iss3_data");
    want(1, 2, 0, 32'h1, "nb_iss3_hazard");

    step();
    b1.wa_en = 1; b1.wa_addr = 3; b1.wa_data = 32'h33;
    want(1, 0, 2, 32'h0, "nb_wr3_old");
    want(1, 1, 2, 32'h1, "nb_wr3_busy");
    want(1, 2, 0, 32'h1, "nb_wr3_hazard");

    step();
    want(1, 0, 2, 32'h33, "nb_wr3_new");
    want(1, 1, 2, 32'h0, "nb_wr3_clear");
    want(1, 2, 0, 32'h0, "nb_wr3_haz_clr");
    want(1, 3, 3, 32'h33, "nb_wr3_print");

    step();
    b0.iss_en = 1; b0.iss_rd = 6;
    rd0(0, 6);
    rd0(1, 7);

    step();
    want(0, 1, 0, 32'h1, "pre_rst_busy6");

    step();
    reset = 1'b1;
    b0.wa_en = 1; b0.wa_addr = 6; b0.wa_data = 32'h66;
    b0.iss_en = 1; b0.iss_rd = 7;

    step();
    reset = 1'b0;
    want(0, 0, 0, 32'h0, "mid_rst_data6");
    want(0, 1, 0, 32'h0, "mid_rst_busy6");
    want(0, 1, 1, 32'h0, "mid_rst_iss7");
    want(0, 0, 1, 32'h0, "mid_rst_data7");
    want(0, 3, 5, 32'h0, "mid_rst_print5");
    want(0, 3, 2, 32'h2ffc, "mid_rst_print_sp");
    want(1, 3, 3, 32'h0, "mid_rst_nb_print3");

    step();
    step();
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d want 0 pending", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
